// File: rtl/r5fp_int_divsqrt_nr.sv
// Iterative radix-2 integer divide / square root on the idiv strobe/ready/done interface.
// Optional R5FP_IDIV_EARLY_EXIT_EN: finish as soon as the partial remainder becomes exactly zero.
module r5fp_int_divsqrt_nr #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] N_i,
  input  logic [W-1:0] D_i,
  input  logic         is_div_i,
  input  logic         strobe_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [W-1:0] Quo_o,
  output logic [W:0]   Rem_o
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  is_div_reg;
  logic                  err_reg;
  logic [W-1:0]          d_reg;
  logic [W-1:0]          q_reg;
  logic [2*W-1:0]        rad_reg;
  logic signed [W+1:0]   p_reg;

  logic signed [W+1:0]   d_ext;
  logic signed [W+1:0]   p_sh;
  logic signed [W+1:0]   div_next;
  logic [W-1:0]          root_part;
  logic [W+3:0]          sq_cur;
  logic [W+3:0]          sq_trial;
  logic [W+1:0]          sq_diff;
  logic                  bit_next;
  logic [W+1:0]          p_next;
  logic [2*W-1:0]        rad_next;
  logic [CW-1:0]         idx;
  logic [W-1:0]          q_next;
  logic                  exit_now;
  logic [W:0]            rem_fix;

  always_comb begin
    d_ext     = $signed({2'b00, d_reg});
    // The first divide step compares N itself; later steps work on the doubled remainder.
    p_sh      = (cnt_reg == CW'(W)) ? p_reg : (p_reg <<< 1);
    div_next  = p_reg[W+1] ? (p_sh + d_ext) : (p_sh - d_ext);
    root_part = q_reg >> cnt_reg;
    sq_cur    = {p_reg, rad_reg[2*W-1 -: 2]};
    sq_trial  = {2'b00, root_part, 2'b01};
    sq_diff   = sq_cur[W+1:0] - sq_trial[W+1:0];
    rad_next  = rad_reg << 2;
    if (is_div_reg) begin
      bit_next = ~div_next[W+1];
      p_next   = div_next;
    end else begin
      bit_next = (sq_cur >= sq_trial);
      p_next   = bit_next ? sq_diff : sq_cur[W+1:0];
    end
    idx    = cnt_reg - CW'(1);
    q_next = q_reg | ({{(W-1){1'b0}}, bit_next} << idx);
`ifdef R5FP_IDIV_EARLY_EXIT_EN
    // A zero root remainder is only final once the unread radicand bits are zero as well.
    exit_now = !err_reg && (p_next == '0) && (is_div_reg || (rad_next == '0));
`else
    exit_now = 1'b0;
`endif
    rem_fix = p_reg[W:0] + (p_reg[W+1] ? {1'b0, d_reg} : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      Quo_o      <= '0;
      Rem_o      <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      err_reg    <= 1'b0;
      d_reg      <= '0;
      q_reg      <= '0;
      rad_reg    <= '0;
      p_reg      <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (strobe_i) begin
            state_reg  <= BUSY;
            ready_o    <= 1'b0;
            cnt_reg    <= CW'(W);
            is_div_reg <= is_div_i;
            err_reg    <= is_div_i && ((D_i == '0) || ({1'b0, N_i} >= {D_i, 1'b0}));
            d_reg      <= D_i;
            q_reg      <= '0;
            rad_reg    <= {N_i, {W{1'b0}}};
            p_reg      <= is_div_i ? {2'b00, N_i} : '0;
          end else begin
            state_reg <= IDLE;
            ready_o   <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            p_reg   <= p_next;
            q_reg   <= q_next;
            rad_reg <= rad_next;
            cnt_reg <= exit_now ? '0 : (cnt_reg - CW'(1));
          end else begin
            // Last BUSY cycle applies the remainder correction and publishes the result.
            state_reg <= DONE;
            ready_o   <= 1'b1;
            done_o    <= 1'b1;
            Quo_o     <= err_reg ? '1 : q_reg;
            Rem_o     <= err_reg ? '1 : rem_fix;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule
